l2_response_serializer: RTL and testbench

Sits directly downstream of the L2 update stage. Captures each completed L2 response packet (one 512-bit line plus header) into a small FIFO and delivers it to the core interconnect as a sequence of 128-bit beats under a valid/ready handshake. Provides an almost-full indication so the L2 request arbiter can stop issuing before in-flight pipeline responses overflow the buffer.

---
 rtl/l2_response_serializer.sv | 160 ++++++++++++++++
 tb/tb_l2_response_serializer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_response_serializer.sv
// L2 response serializer: buffers complete L2 response packets in a small
// FIFO and streams each one to the interconnect as 128-bit beats.

package l2rsp_pkg;
  localparam int CACHE_LINE_BYTES = 64;
  localparam int CORE_BITS        = 2;
  localparam int ID_BITS          = 2;
  localparam int ADDR_BITS        = 26;

  typedef enum logic [1:0] {
    L2RSP_LOAD_ACK  = 2'd0,
    L2RSP_STORE_ACK = 2'd1,
    L2RSP_FLUSH_ACK = 2'd2
  } l2rsp_type_t;

  typedef struct packed {
    logic                          valid;
    logic                          status;
    logic [CORE_BITS-1:0]          core;
    logic [ID_BITS-1:0]            id;
    l2rsp_type_t                   packet_type;
    logic                          cache_type;
    logic [CACHE_LINE_BYTES*8-1:0] data;
    logic [ADDR_BITS-1:0]          address;
  } l2rsp_packet_t;
endpackage

// state | meaning
// IDLE  | FIFO empty, nothing on the output
// SEND  | head packet presented beat by beat, beat_q selects the slice
module l2_response_serializer
  import l2rsp_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int AF_FREE    = 2,
  parameter int BEAT_BITS  = 128,
  localparam int BEATS     = CACHE_LINE_BYTES * 8 / BEAT_BITS,
  localparam int BEAT_W    = $clog2(BEATS),
  localparam int PTR_W     = $clog2(FIFO_DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  l2rsp_packet_t         l2_response,
  output logic                  l2s_almost_full,
  output logic                  l2s_overflow,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [CORE_BITS-1:0]  rsp_core,
  output logic [ID_BITS-1:0]    rsp_id,
  output l2rsp_type_t           rsp_packet_type,
  output logic                  rsp_cache_type,
  output logic                  rsp_status,
  output logic [ADDR_BITS-1:0]  rsp_address,
  output logic [BEAT_BITS-1:0]  rsp_data,
  output logic [BEAT_W-1:0]     rsp_beat,
  output logic                  rsp_last
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                overflow_q, overflow_d;
  l2rsp_packet_t       mem_q [FIFO_DEPTH];
  l2rsp_packet_t       mem_d [FIFO_DEPTH];

  l2rsp_packet_t       head;
  logic                head_flush, head_last, live, hs, pop, push, full;

  // Head decode and handshake qualification; live is only true while an
  // entry written by a valid push sits at the head.
  always_comb begin
    head       = mem_q[rd_ptr_q];
    head_flush = (head.packet_type == L2RSP_FLUSH_ACK);
    head_last  = head_flush || (beat_q == BEAT_W'(BEATS - 1));
    live       = (state_q == SEND) && head.valid;
    hs         = live && rsp_ready;
    pop        = hs && head_last;
    full       = (count_q == CNT_W'(FIFO_DEPTH));
    // A pop at full frees the slot in the same cycle, so the push still fits.
    push       = l2_response.valid && (!full || pop);
  end

  // Next-state for FIFO bookkeeping, beat counter, overflow flag and FSM.
  always_comb begin
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    beat_d     = beat_q;
    overflow_d = overflow_q;
    state_d    = state_q;
    mem_d      = mem_q;

    if (push) begin
      mem_d[wr_ptr_q] = l2_response;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (hs) beat_d = head_last ? '0 : beat_q + 1'b1;
    if (l2_response.valid && !push) overflow_d = 1'b1;

    unique case (state_q)
      IDLE:    if (push) state_d = SEND;
      SEND:    if (pop && (count_q == CNT_W'(1)) && !push) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control registers; reset discards every buffered entry at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      beat_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      beat_q     <= beat_d;
      overflow_q <= overflow_d;
    end
  end

  // Packet storage carries no reset; outputs are gated by live instead.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Outputs come only from registered head, beat counter and count.
  always_comb begin
    rsp_valid       = live;
    rsp_core        = live ? head.core        : '0;
    rsp_id          = live ? head.id          : '0;
    rsp_packet_type = live ? head.packet_type : L2RSP_LOAD_ACK;
    rsp_cache_type  = live ? head.cache_type  : 1'b0;
    rsp_status      = live ? head.status      : 1'b0;
    rsp_address     = live ? head.address     : '0;
    rsp_beat        = live ? beat_q           : '0;
    rsp_last        = live && head_last;
    rsp_data        = (live && !head_flush) ? head.data[beat_q*BEAT_BITS +: BEAT_BITS] : '0;
    l2s_overflow    = overflow_q;
    l2s_almost_full = (FIFO_DEPTH - int'(count_q)) <= AF_FREE;
  end

endmodule

// File: tb/tb_l2_response_serializer.sv
// Directed bench for l2_response_serializer. Inputs change and outputs are
// sampled on the falling clock edge.

module tb_l2_response_serializer;
  import l2rsp_pkg::*;

  logic           clk = 1'b0;
  logic           reset;
  l2rsp_packet_t  l2_response;
  logic           l2s_almost_full, l2s_overflow;
  logic           rsp_valid, rsp_ready;
  logic [1:0]     rsp_core, rsp_id;
  l2rsp_type_t    rsp_packet_type;
  logic           rsp_cache_type, rsp_status;
  logic [25:0]    rsp_address;
  logic [127:0]   rsp_data;
  logic [1:0]     rsp_beat;
  logic           rsp_last;

  int checks = 0;
  int errors = 0;

  l2_response_serializer dut (
    .clk(clk), .reset(reset), .l2_response(l2_response),
    .l2s_almost_full(l2s_almost_full), .l2s_overflow(l2s_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_core(rsp_core), .rsp_id(rsp_id), .rsp_packet_type(rsp_packet_type),
    .rsp_cache_type(rsp_cache_type), .rsp_status(rsp_status),
    .rsp_address(rsp_address), .rsp_data(rsp_data),
    .rsp_beat(rsp_beat), .rsp_last(rsp_last)
  );

  always #5 clk = ~clk;

  // Byte i of the line is seed*64+i, so seed 0 gives bytes 0x00..0x3F.
  function automatic l2rsp_packet_t mk(l2rsp_type_t t, logic [1:0] core,
                                       logic [1:0] id, int seed);
    l2rsp_packet_t p;
    p             = '0;
    p.valid       = 1'b1;
    p.status      = seed[0];
    p.core        = core;
    p.id          = id;
    p.packet_type = t;
    p.cache_type  = seed[1];
    p.address     = 26'(seed * 17 + 3);
    for (int i = 0; i < 64; i++) p.data[i*8 +: 8] = 8'(seed * 64 + i);
    return p;
  endfunction

  task automatic test_reset();
    reset = 1'b1; rsp_ready = 1'b0; l2_response = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rsp_valid, l2s_almost_full, l2s_overflow, rsp_beat, rsp_last, rsp_id, rsp_core, rsp_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h exp 0", {rsp_valid, l2s_almost_full, l2s_overflow, rsp_beat, rsp_last, rsp_id, rsp_core, rsp_data});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_load();
    l2rsp_packet_t p;
    p = mk(L2RSP_LOAD_ACK, 2'd1, 2'd3, 0);
    rsp_ready = 1'b1; l2_response = p;
    @(negedge clk);
    l2_response.valid = 1'b0;
    checks++;
    if (rsp_data !== 128'h0f0e0d0c0b0a09080706050403020100) begin
      errors++;
      $display("FAIL load_beat0_value: got %h exp 0f0e0d0c0b0a09080706050403020100", rsp_data);
    end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if ({rsp_valid, rsp_beat, rsp_last, rsp_id, rsp_data} !== {1'b1, 2'(b), (b == 3), p.id, p.data[b*128 +: 128]}) begin
        errors++;
        $display("FAIL load_beat%0d: got %h exp %h", b, {rsp_valid, rsp_beat, rsp_last, rsp_id, rsp_data},
                 {1'b1, 2'(b), (b == 3), p.id, p.data[b*128 +: 128]});
      end
      checks++;
      if ({rsp_core, rsp_packet_type, rsp_status, rsp_cache_type, rsp_address} !== {p.core, p.packet_type, p.status, p.cache_type, p.address}) begin
        errors++;
        $display("FAIL load_header%0d: got %h exp %h", b, {rsp_core, rsp_packet_type, rsp_status, rsp_cache_type, rsp_address},
                 {p.core, p.packet_type, p.status, p.cache_type, p.address});
      end
      @(negedge clk);
    end
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL load_idle_after: got %b exp 0", rsp_valid); end
  endtask

  task automatic test_flush();
    rsp_ready = 1'b1; l2_response = mk(L2RSP_FLUSH_ACK, 2'd1, 2'd2, 1);
    @(negedge clk);
    l2_response.valid = 1'b0;
    checks++;
    if ({rsp_valid, rsp_beat, rsp_last, rsp_id, rsp_core, rsp_packet_type, rsp_data} !== {1'b1, 2'd0, 1'b1, 2'd2, 2'd1, L2RSP_FLUSH_ACK, 128'd0}) begin
      errors++;
      $display("FAIL flush_beat: got %h exp %h", {rsp_valid, rsp_beat, rsp_last, rsp_id, rsp_core, rsp_packet_type, rsp_data},
               {1'b1, 2'd0, 1'b1, 2'd2, 2'd1, L2RSP_FLUSH_ACK, 128'd0});
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_single_beat: got %b exp 0", rsp_valid); end
  endtask

  task automatic test_ready_toggle();
    l2rsp_packet_t p;
    int n;
    p = mk(L2RSP_LOAD_ACK, 2'd2, 2'd1, 5);
    n = 0;
    rsp_ready = 1'b0; l2_response = p;
    @(negedge clk);
    l2_response.valid = 1'b0;
    for (int i = 0; i < 20 && n < 4; i++) begin
      checks++;
      if ({rsp_valid, rsp_beat, rsp_last, rsp_data} !== {1'b1, 2'(n), (n == 3), p.data[n*128 +: 128]}) begin
        errors++;
        $display("FAIL toggle_hold c%0d: got %h exp %h", i, {rsp_valid, rsp_beat, rsp_last, rsp_data},
                 {1'b1, 2'(n), (n == 3), p.data[n*128 +: 128]});
      end
      rsp_ready = (i % 2 == 0);
      @(negedge clk);
      if (rsp_ready) n++;
    end
    rsp_ready = 1'b0;
    checks++;
    if (n != 4 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL toggle_complete: got beats %0d valid %b exp beats 4 valid 0", n, rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    l2rsp_packet_t ps [4];
    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ps[k] = mk(L2RSP_STORE_ACK, 2'(k), 2'(k), 10 + k);
      l2_response = ps[k];
      @(negedge clk);
      checks++;
      if (l2s_almost_full !== (k >= 1)) begin
        errors++;
        $display("FAIL af_after_push%0d: got %b exp %b", k + 1, l2s_almost_full, (k >= 1));
      end
    end
    l2_response.valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({rsp_valid, rsp_beat, rsp_id, rsp_data, l2s_overflow} !== {1'b1, 2'd0, 2'd0, ps[0].data[127:0], 1'b0}) begin
        errors++;
        $display("FAIL stall_hold c%0d: got %h exp %h", c, {rsp_valid, rsp_beat, rsp_id, rsp_data, l2s_overflow},
                 {1'b1, 2'd0, 2'd0, ps[0].data[127:0], 1'b0});
      end
      @(negedge clk);
    end
    l2_response = mk(L2RSP_STORE_ACK, 2'd0, 2'd0, 20);
    @(negedge clk);
    l2_response.valid = 1'b0;
    checks++;
    if ({l2s_overflow, l2s_almost_full, rsp_id, rsp_beat} !== {1'b1, 1'b1, 2'd0, 2'd0}) begin
      errors++;
      $display("FAIL overflow_drop: got %h exp %h", {l2s_overflow, l2s_almost_full, rsp_id, rsp_beat}, {1'b1, 1'b1, 2'd0, 2'd0});
    end
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < 4; b++) begin
        checks++;
        if ({rsp_valid, rsp_id, rsp_beat, rsp_last, rsp_data} !== {1'b1, 2'(k), 2'(b), (b == 3), ps[k].data[b*128 +: 128]}) begin
          errors++;
          $display("FAIL drain p%0d b%0d: got %h exp %h", k, b, {rsp_valid, rsp_id, rsp_beat, rsp_last, rsp_data},
                   {1'b1, 2'(k), 2'(b), (b == 3), ps[k].data[b*128 +: 128]});
        end
        @(negedge clk);
      end
    end
    checks++;
    if ({rsp_valid, l2s_overflow, l2s_almost_full} !== 3'b010) begin
      errors++;
      $display("FAIL drain_end_sticky: got %b exp 010", {rsp_valid, l2s_overflow, l2s_almost_full});
    end
  endtask

  task automatic test_reset_mid();
    l2rsp_packet_t p;
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      l2_response = mk(L2RSP_LOAD_ACK, 2'd0, 2'(k + 1), 30 + k);
      @(negedge clk);
    end
    l2_response.valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({rsp_beat, rsp_id, l2s_almost_full, l2s_overflow} !== {2'd2, 2'd1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL pre_reset_state: got %h exp %h", {rsp_beat, rsp_id, l2s_almost_full, l2s_overflow}, {2'd2, 2'd1, 1'b1, 1'b1});
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({rsp_valid, l2s_almost_full, l2s_overflow, rsp_beat} !== 5'd0) begin
      errors++;
      $display("FAIL async_reset: got %b exp 00000", {rsp_valid, l2s_almost_full, l2s_overflow, rsp_beat});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_discard: got %b exp 0", rsp_valid); end
    p = mk(L2RSP_STORE_ACK, 2'd3, 2'd2, 40);
    l2_response = p;
    @(negedge clk);
    l2_response.valid = 1'b0;
    checks++;
    if ({rsp_valid, rsp_beat, rsp_id, rsp_data} !== {1'b1, 2'd0, 2'd2, p.data[127:0]}) begin
      errors++;
      $display("FAIL post_reset_push: got %h exp %h", {rsp_valid, rsp_beat, rsp_id, rsp_data}, {1'b1, 2'd0, 2'd2, p.data[127:0]});
    end
    repeat (4) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL post_reset_drain: got %b exp 0", rsp_valid); end
  endtask

  task automatic test_full_with_pop();
    l2rsp_packet_t ps [5];
    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ps[k] = mk(L2RSP_LOAD_ACK, 2'd1, 2'(k), 50 + k);
      l2_response = ps[k];
      @(negedge clk);
    end
    l2_response.valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({rsp_beat, rsp_last, rsp_id} !== {2'd3, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL head_last_beat: got %h exp %h", {rsp_beat, rsp_last, rsp_id}, {2'd3, 1'b1, 2'd0});
    end
    ps[4] = mk(L2RSP_STORE_ACK, 2'd2, 2'd0, 60);
    l2_response = ps[4];
    @(negedge clk);
    l2_response.valid = 1'b0;
    checks++;
    if ({l2s_overflow, l2s_almost_full, rsp_id, rsp_beat} !== {1'b0, 1'b1, 2'd1, 2'd0}) begin
      errors++;
      $display("FAIL push_pop_full: got %h exp %h", {l2s_overflow, l2s_almost_full, rsp_id, rsp_beat}, {1'b0, 1'b1, 2'd1, 2'd0});
    end
    for (int k = 1; k < 5; k++) begin
      for (int b = 0; b < 4; b++) begin
        checks++;
        if ({rsp_valid, rsp_id, rsp_beat, rsp_data} !== {1'b1, ps[k].id, 2'(b), ps[k].data[b*128 +: 128]}) begin
          errors++;
          $display("FAIL full_drain p%0d b%0d: got %h exp %h", k, b, {rsp_valid, rsp_id, rsp_beat, rsp_data},
                   {1'b1, ps[k].id, 2'(b), ps[k].data[b*128 +: 128]});
        end
        @(negedge clk);
      end
    end
    checks++;
    if ({rsp_valid, l2s_overflow} !== 2'b00) begin
      errors++;
      $display("FAIL full_drain_end: got %b exp 00", {rsp_valid, l2s_overflow});
    end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_flush();
    test_ready_toggle();
    test_back_to_back();
    test_reset_mid();
    test_full_with_pop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
